uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a DATA_W-bit word as start, data (LSB
// first), optional parity and one or two stop bits, pacing every bit with
// OSR pulses of the oversample tick.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   osr_tick_i              oversample tick pulse from the baud generator
//   baud_en_o               runs the baud generator while a frame is active
//   tx_data_i, tx_valid_i   word to send and its valid strobe
//   tx_ready_o              high while idle and able to accept a word
//   parity_en_i/odd_i       parity append / odd (1) or even (0) parity
//   stop2_i                 two stop bits when high
//   tx_o                    serial line, idle high
//   busy_o, done_o          frame in progress / one-cycle completion pulse
module uart_tx_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OSR    = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              osr_tick_i,
    output logic              baud_en_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic              parity_en_i,
    input  logic              parity_odd_i,
    input  logic              stop2_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned CNT_W = $clog2(OSR);
    localparam int unsigned IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OSR - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state_q,    state_d;
    logic [CNT_W-1:0]  tick_q,     tick_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic [DATA_W-1:0] shift_q,    shift_d;
    logic              par_en_q,   par_en_d;
    logic              par_bit_q,  par_bit_d;
    logic              stop2_q,    stop2_d;
    logic              stop_sec_q, stop_sec_d;
    logic              tx_q,       tx_d;
    logic              done_q,     done_d;
    logic              busy_q,     busy_d;
    logic              ready_q,    ready_d;
    logic              bit_end;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_sec_d = stop_sec_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        bit_end = osr_tick_i && (tick_q == TICK_LAST);

        if ((state_q != S_IDLE) && osr_tick_i) begin
            tick_d = bit_end ? '0 : tick_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_valid_i) begin
                    shift_d    = tx_data_i;
                    par_en_d   = parity_en_i;
                    // Parity value is resolved once at accept time
                    par_bit_d  = (^tx_data_i) ^ parity_odd_i;
                    stop2_d    = stop2_i;
                    tick_d     = '0;
                    idx_d      = '0;
                    stop_sec_d = 1'b0;
                    tx_d       = 1'b0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_sec_q) begin
                        stop_sec_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_sec_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_sec_q <= stop_sec_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign tx_o       = tx_q;
    assign done_o     = done_q;
    assign busy_o     = busy_q;
    assign baud_en_o  = busy_q;
    assign tx_ready_o = ready_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: table of directed frames, hand-written corner
// sequences and randomized frames checked cycle by cycle against a
// frame-level model (bit list indexed by ticks seen since accept).
module tb_uart_tx_ctrl;

    localparam int OSR = 16;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       osr_tick_i;
    logic       baud_en_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       parity_en_i;
    logic       parity_odd_i;
    logic       stop2_i;
    logic       tx_o;
    logic       busy_o;
    logic       done_o;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx_ctrl #(.DATA_W(8), .OSR(OSR)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .osr_tick_i  (osr_tick_i),
        .baud_en_o   (baud_en_o),
        .tx_data_i   (tx_data_i),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .parity_en_i (parity_en_i),
        .parity_odd_i(parity_odd_i),
        .stop2_i     (stop2_i),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    // tick modes: 0 = tied high, 1 = one pulse every per cycles, 2 = random
    typedef struct {
        string      name;
        logic [7:0] d;
        bit         pen;
        bit         podd;
        bit         s2;
        int         tmode;
        int         per;
        bit         scr;
        logic [11:0] bits;
        int         nbits;
        int         len;
    } vec_t;

    vec_t vecs[6];

    // Observed vector: {tx, busy, ready, baud_en, done}
    function automatic logic [4:0] obs();
        return {tx_o, busy_o, tx_ready_o, baud_en_o, done_o};
    endfunction

    task automatic check(input string nm, input int cyc, input logic [4:0] act, input logic [4:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %b expected %b (tx,busy,ready,baud,done)", nm, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Frame model: start 0, data LSB first, parity making the count of
    // ones even (or odd), then stop ones.
    function automatic logic [11:0] model_bits(input logic [7:0] d, input bit pen, input bit podd,
                                               input bit s2, output int nb);
        logic [11:0] b;
        int k;
        b = '1;
        k = 0;
        b[k] = 1'b0;
        k++;
        for (int i = 0; i < 8; i++) begin
            b[k] = d[i];
            k++;
        end
        if (pen) begin
            b[k] = (($countones(d) % 2) == 1) ^ podd;
            k++;
        end
        k += s2 ? 2 : 1;
        nb = k;
        return b;
    endfunction

    // Sends one frame and checks every cycle until done. Entered and left
    // at #1 after a rising edge. waited = idle cycles spent before accept.
    task automatic run_frame(input string name, input logic [7:0] d, input bit pen, input bit podd,
                             input bit s2, input int tmode, input int per, input bit scr,
                             input bit hold, input logic [7:0] next_d,
                             input logic [11:0] bits, input int nbits,
                             output int len, output int waited);
        int t;
        int j;
        bit tk;
        bit fin;
        logic [4:0] exp;
        waited = 0;
        len = 0;
        while (tx_ready_o !== 1'b1 && waited < 20000) begin
            osr_tick_i = 1'($urandom_range(0, 1));
            @(posedge clk_i);
            #1;
            waited++;
        end
        if (waited >= 20000) begin
            check_int({name, " ready timeout"}, waited, 0);
            return;
        end
        tx_data_i    = d;
        parity_en_i  = pen;
        parity_odd_i = podd;
        stop2_i      = s2;
        tx_valid_i   = 1'b1;
        osr_tick_i   = 1'b1;
        @(posedge clk_i);
        #1;
        check({name, " accept"}, 0, obs(), 5'b0_1_0_1_0);
        if (hold) tx_data_i = next_d;
        else tx_valid_i = 1'b0;
        t = 0;
        j = 0;
        fin = 1'b0;
        while (!fin) begin
            j++;
            if (j > 20000) begin
                check_int({name, " done timeout"}, j, len);
                break;
            end
            case (tmode)
                0:       tk = 1'b1;
                1:       tk = ((j % per) == 0);
                default: tk = ($urandom_range(0, 2) == 0);
            endcase
            if (scr) begin
                tx_data_i    = 8'($urandom);
                parity_en_i  = 1'($urandom);
                parity_odd_i = 1'($urandom);
                stop2_i      = 1'($urandom);
                tx_valid_i   = 1'($urandom);
            end
            osr_tick_i = tk;
            @(posedge clk_i);
            #1;
            if (tk) t++;
            if (t >= nbits * OSR) begin
                fin = 1'b1;
                len = j;
                exp = 5'b1_0_1_0_1;
            end else begin
                exp = {bits[t / OSR], 4'b1010};
            end
            check(name, j, obs(), exp);
        end
        if (!hold) tx_valid_i = 1'b0;
    endtask

    initial begin
        int len;
        int w;
        int nb;
        logic [7:0]  rd;
        logic [11:0] rb;
        bit rp, ro, rs;

        vecs[0] = '{"a5_plain",     8'hA5, 0, 0, 0, 0, 1, 0, 12'h34A, 10, 160};
        vecs[1] = '{"a5_even",      8'hA5, 1, 0, 0, 0, 1, 0, 12'h54A, 11, 176};
        vecs[2] = '{"a5_odd",       8'hA5, 1, 1, 0, 0, 1, 0, 12'h74A, 11, 176};
        vecs[3] = '{"a5_stop2",     8'hA5, 0, 0, 1, 0, 1, 0, 12'h74A, 11, 176};
        vecs[4] = '{"3c_per5_scr",  8'h3C, 1, 1, 1, 1, 5, 1, 12'hE78, 12, 960};
        vecs[5] = '{"00_even_s2",   8'h00, 1, 0, 1, 0, 1, 0, 12'hC00, 12, 192};

        reset_i      = 1'b1;
        osr_tick_i   = 1'b0;
        tx_data_i    = 8'h00;
        tx_valid_i   = 1'b0;
        parity_en_i  = 1'b0;
        parity_odd_i = 1'b0;
        stop2_i      = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("in_reset", 0, obs(), 5'b1_0_1_0_0);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("after_reset", 0, obs(), 5'b1_0_1_0_0);

        // Ticks while idle must not disturb anything
        osr_tick_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            check("idle_ticks", i, obs(), 5'b1_0_1_0_0);
        end

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].name, vecs[v].d, vecs[v].pen, vecs[v].podd, vecs[v].s2,
                      vecs[v].tmode, vecs[v].per, vecs[v].scr, 1'b0, 8'h00,
                      vecs[v].bits, vecs[v].nbits, len, w);
            check_int({vecs[v].name, " len"}, len, vecs[v].len);
        end

        // Back-to-back with valid held high: one idle cycle between frames
        run_frame("b2b_01", 8'h01, 0, 0, 0, 0, 1, 0, 1'b1, 8'h80, 12'h202, 10, len, w);
        check_int("b2b_01 len", len, 160);
        run_frame("b2b_80", 8'h80, 0, 0, 0, 0, 1, 0, 1'b0, 8'h00, 12'h300, 10, len, w);
        check_int("b2b_80 len", len, 160);
        check_int("b2b idle gap", w, 0);

        // Reset during data bit 3
        @(posedge clk_i);
        #1;
        tx_data_i  = 8'hA5;
        tx_valid_i = 1'b1;
        osr_tick_i = 1'b1;
        @(posedge clk_i);
        #1;
        tx_valid_i = 1'b0;
        repeat (70) @(posedge clk_i);
        #1;
        check("rst_mid bit3", 70, obs(), 5'b0_1_0_1_0);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        check("rst_mid after", 0, obs(), 5'b1_0_1_0_0);
        for (int i = 1; i < 20; i++) begin
            @(posedge clk_i);
            #1;
            check("rst_mid idle", i, obs(), 5'b1_0_1_0_0);
        end
        rb = model_bits(8'h3C, 0, 0, 0, nb);
        run_frame("post_rst", 8'h3C, 0, 0, 0, 0, 1, 0, 1'b0, 8'h00, rb, nb, len, w);
        check_int("post_rst len", len, 160);

        // Missing ticks stall the frame with the line held
        tx_data_i  = 8'hFF;
        tx_valid_i = 1'b1;
        osr_tick_i = 1'b0;
        @(posedge clk_i);
        #1;
        tx_valid_i = 1'b0;
        repeat (200) @(posedge clk_i);
        #1;
        check("stall", 200, obs(), 5'b0_1_0_1_0);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        // Randomized frames, random tick arrival, inputs scrambled mid-frame
        for (int r = 0; r < 8; r++) begin
            rd = 8'($urandom);
            rp = 1'($urandom);
            ro = 1'($urandom);
            rs = 1'($urandom);
            rb = model_bits(rd, rp, ro, rs, nb);
            run_frame($sformatf("rand%0d_%02h", r, rd), rd, rp, ro, rs, 2, 1, 1, 1'b0, 8'h00,
                      rb, nb, len, w);
        end

        @(posedge clk_i);
        #1;
        check("final_idle", 0, obs(), 5'b1_0_1_0_0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
